// File: rtl/uart_param_core.sv
// uart_param_core
//   Full-duplex UART with runtime frame format (5..DATA_MAX data bits,
//   none/even/odd parity, 1 or 2 stop bits) and a runtime baud divisor.
//   RX oversamples 16x and samples each bit once at the middle tick.
//   RX rejects start-bit glitches and reports parity, framing and overrun errors.
//
// Ports
//   clk_i / rst_ni              system clock, async active-low reset
//   baud_div_i                  clk cycles per oversample tick (0 acts as 1)
//   n_bits_i                    data bits per frame, clamped to [5, DATA_MAX]
//   parity_mode_i               00 none, 01 even, 10 odd, 11 none
//   stop_bits_i                 0 = one stop bit, 1 = two (TX only)
//   tx_data_i/tx_valid_i        word to send and its valid strobe
//   tx_ready_o                  transmitter idle, accepts a word
//   tx_done_o                   1-cycle pulse when the last stop bit ends
//   tx_o                        serial out, idle high
//   rx_i                        serial in, asynchronous
//   rx_data_o/rx_valid_o        received word (zero-extended) and valid
//   rx_ready_i                  consumer accepts rx_data_o
//   rx_parity_err_o             parity mismatch on rx_data_o
//   rx_frame_err_o              first stop bit sampled low on rx_data_o
//   rx_overrun_o                sticky: word overwritten while still unread
//
// TX states                     RX states
//   TX_IDLE  | ready for word     RX_IDLE  | waiting for start edge / line high
//   TX_ARM   | wait first tick    RX_START | start bit, glitch check at mid
//   TX_START | start bit          RX_DATA  | data bits
//   TX_DATA  | data bits          RX_PAR   | parity bit
//   TX_PAR   | parity bit         RX_STOP  | first stop bit, completes word
//   TX_STOP1 | first stop bit
//   TX_STOP2 | second stop bit
module uart_param_core #(
  parameter int DATA_MAX = 9,
  parameter int DIV_W    = 16,
  parameter int OVS      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DIV_W-1:0]    baud_div_i,
  input  logic [3:0]          n_bits_i,
  input  logic [1:0]          parity_mode_i,
  input  logic                stop_bits_i,
  input  logic [DATA_MAX-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                tx_done_o,
  output logic                tx_o,
  input  logic                rx_i,
  output logic [DATA_MAX-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                rx_parity_err_o,
  output logic                rx_frame_err_o,
  output logic                rx_overrun_o
);

  localparam int              PH_W    = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);
  localparam logic [3:0]      NB_MAX  = 4'(DATA_MAX);

  // Oversample tick: down-counter, reload value sampled only at terminal count
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;
  assign tick = (tick_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 tick_cnt_q <= '0;
    else if (tick)               tick_cnt_q <= (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
    else                         tick_cnt_q <= tick_cnt_q - DIV_W'(1);
  end

  // Frame-format decode shared by both directions
  logic [3:0]          nb_eff;
  logic                par_en, par_odd;
  logic [DATA_MAX-1:0] tx_masked;
  always_comb begin
    if (n_bits_i < 4'd5)        nb_eff = 4'd5;
    else if (n_bits_i > NB_MAX) nb_eff = NB_MAX;
    else                        nb_eff = n_bits_i;
    tx_masked = '0;
    for (int i = 0; i < DATA_MAX; i++)
      if (4'(i) < nb_eff) tx_masked[i] = tx_data_i[i];
  end
  assign par_en  = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
  assign par_odd = (parity_mode_i == 2'b10);

  // ---------------- TX ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_ARM, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2
  } tx_st_e;

  tx_st_e              tx_st_q;
  logic [PH_W-1:0]     tx_ph_q;
  logic [DATA_MAX-1:0] tx_sh_q;
  logic [3:0]          tx_left_q;
  logic                tx_par_q, tx_par_en_q, tx_stop2_q;
  logic                tx_q, tx_ready_q, tx_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q     <= TX_IDLE;
      tx_ph_q     <= '0;
      tx_sh_q     <= '0;
      tx_left_q   <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_q        <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_st_q)
        TX_IDLE: begin
          if (tx_valid_i && tx_ready_q) begin
            tx_sh_q     <= tx_masked;
            tx_left_q   <= nb_eff;
            tx_par_q    <= (^tx_masked) ^ par_odd;
            tx_par_en_q <= par_en;
            tx_stop2_q  <= stop_bits_i;
            tx_ready_q  <= 1'b0;
            tx_st_q     <= TX_ARM;
          end
        end
        TX_ARM: begin
          if (tick) begin
            tx_q    <= 1'b0;
            tx_ph_q <= '0;
            tx_st_q <= TX_START;
          end
        end
        default: begin
          if (tick) begin
            if (tx_ph_q != PH_LAST) begin
              tx_ph_q <= tx_ph_q + PH_W'(1);
            end else begin
              tx_ph_q <= '0;
              // tx_left_q counts data bits still to be shifted out
              if ((tx_st_q == TX_START) || (tx_st_q == TX_DATA && tx_left_q != 4'd0)) begin
                tx_q      <= tx_sh_q[0];
                tx_sh_q   <= tx_sh_q >> 1;
                tx_left_q <= tx_left_q - 4'd1;
                tx_st_q   <= TX_DATA;
              end else if (tx_st_q == TX_DATA && tx_par_en_q) begin
                tx_q    <= tx_par_q;
                tx_st_q <= TX_PAR;
              end else if (tx_st_q == TX_DATA || tx_st_q == TX_PAR) begin
                tx_q    <= 1'b1;
                tx_st_q <= TX_STOP1;
              end else if (tx_st_q == TX_STOP1 && tx_stop2_q) begin
                tx_st_q <= TX_STOP2;
              end else begin
                tx_st_q    <= TX_IDLE;
                tx_ready_q <= 1'b1;
                tx_done_q  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = tx_ready_q;
  assign tx_done_o  = tx_done_q;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_e;

  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_e              rx_st_q;
  logic                rx_armed_q;
  logic [PH_W-1:0]     rx_ph_q;
  logic [DATA_MAX-1:0] rx_sh_q;
  logic [3:0]          rx_idx_q, rx_nb_q;
  logic                rx_par_en_q, rx_odd_q, rx_par_q, rx_perr_q;
  logic [DATA_MAX-1:0] rx_data_q;
  logic                rx_valid_q, rx_perr_out_q, rx_ferr_q, rx_ovr_q;
  logic                rx_sample;

  assign rx_sample = tick && (rx_ph_q == PH_MID);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st_q       <= RX_IDLE;
      rx_armed_q    <= 1'b0;
      rx_ph_q       <= '0;
      rx_sh_q       <= '0;
      rx_idx_q      <= '0;
      rx_nb_q       <= 4'd5;
      rx_par_en_q   <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_par_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
      if (tick) rx_ph_q <= (rx_ph_q == PH_LAST) ? '0 : rx_ph_q + PH_W'(1);
      case (rx_st_q)
        RX_IDLE: begin
          // after a framing error the line must be seen high before a new edge counts
          if (!rx_armed_q) begin
            rx_armed_q <= rx_s2_q;
          end else if (rx_prev_q && !rx_s2_q) begin
            rx_ph_q     <= '0;
            rx_sh_q     <= '0;
            rx_idx_q    <= '0;
            rx_nb_q     <= nb_eff;
            rx_par_en_q <= par_en;
            rx_odd_q    <= par_odd;
            rx_par_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_st_q     <= RX_START;
          end
        end
        RX_START: if (rx_sample) rx_st_q <= rx_s2_q ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          if (rx_sample) begin
            rx_sh_q[rx_idx_q] <= rx_s2_q;
            rx_par_q          <= rx_par_q ^ rx_s2_q;
            rx_idx_q          <= rx_idx_q + 4'd1;
            if (rx_idx_q == rx_nb_q - 4'd1) rx_st_q <= rx_par_en_q ? RX_PAR : RX_STOP;
          end
        end
        RX_PAR: begin
          if (rx_sample) begin
            rx_perr_q <= rx_s2_q ^ rx_par_q ^ rx_odd_q;
            rx_st_q   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            rx_data_q     <= rx_sh_q;
            rx_perr_out_q <= rx_perr_q;
            rx_ferr_q     <= !rx_s2_q;
            rx_valid_q    <= 1'b1;
            rx_armed_q    <= rx_s2_q;
            if (rx_valid_q && !rx_ready_i) rx_ovr_q <= 1'b1;
            rx_st_q       <= RX_IDLE;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_out_q;
  assign rx_frame_err_o  = rx_ferr_q;
  assign rx_overrun_o    = rx_ovr_q;

endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core
//   Directed bench for uart_param_core at baud_div = 4 (64 clk per bit).
//   Frames are given as hand-built bit vectors, LSB = start bit.
module tb_uart_param_core;
  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [3:0]  n_bits;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_done, tx_w;
  logic        rx_drv, loopback, rx_line;
  logic [8:0]  rx_data;
  logic        rx_valid, rx_ready, rx_perr, rx_ferr, rx_ovr;

  int checks = 0;
  int errors = 0;

  assign rx_line = loopback ? tx_w : rx_drv;

  always #5 clk = ~clk;

  uart_param_core dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .baud_div_i      (baud_div),
    .n_bits_i        (n_bits),
    .parity_mode_i   (parity_mode),
    .stop_bits_i     (stop_bits),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .tx_done_o       (tx_done),
    .tx_o            (tx_w),
    .rx_i            (rx_line),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (rx_ready),
    .rx_parity_err_o (rx_perr),
    .rx_frame_err_o  (rx_ferr),
    .rx_overrun_o    (rx_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Send one word and follow Tx cycle by cycle against the expected frame.
  task automatic tx_frame(input logic [8:0] data, input logic [3:0] nb, input logic [1:0] pm,
                          input logic sb, input logic [15:0] frame, input int nbits,
                          input string tag);
    int wait_n, bad_bits, bad_ready, bad_done;
    @(negedge clk);
    n_bits = nb; parity_mode = pm; stop_bits = sb; tx_data = data; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk({tag, "_ready_drop"}, 32'(tx_ready), 0);
    wait_n = 0;
    while (tx_w && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, "_start_low"}, 32'(tx_w), 0);
    bad_bits = 0; bad_ready = 0; bad_done = 0;
    for (int k = 0; k < nbits * BIT_CLKS; k++) begin
      if (tx_w !== frame[k / BIT_CLKS]) bad_bits++;
      if (tx_ready !== 1'b0) bad_ready++;
      if (tx_done !== 1'b0) bad_done++;
      @(negedge clk);
    end
    chk({tag, "_bit_errs"}, bad_bits, 0);
    chk({tag, "_ready_low_errs"}, bad_ready, 0);
    chk({tag, "_early_done"}, bad_done, 0);
    chk({tag, "_done"}, 32'(tx_done), 1);
    chk({tag, "_ready_back"}, 32'(tx_ready), 1);
    chk({tag, "_idle_high"}, 32'(tx_w), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(tx_done), 0);
  endtask

  task automatic rx_send(input logic [15:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic rx_ack();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; baud_div = 16'd4; n_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1; loopback = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_w), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_flags", 32'({rx_perr, rx_ferr, rx_ovr}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
    tx_frame(9'h0A5, 4'd8, 2'b00, 1'b0, 16'h034A, 10, "tx8n1");

    // 7O2 loopback; bits 7/8 of the word must be ignored, odd parity of 0x35 = 1
    loopback = 1'b1;
    tx_frame(9'h1B5, 4'd7, 2'b10, 1'b1, 16'h076A, 11, "lb7o2");
    chk("lb_rx_valid", 32'(rx_valid), 1);
    chk("lb_rx_data", 32'(rx_data), 32'h035);
    chk("lb_rx_perr", 32'(rx_perr), 0);
    chk("lb_rx_ferr", 32'(rx_ferr), 0);
    rx_ack();
    chk("lb_ack_valid", 32'(rx_valid), 0);
    loopback = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // 8E1 0x0F with parity bit 1 instead of 0
    n_bits = 4'd8; parity_mode = 2'b01; stop_bits = 1'b0;
    rx_send(16'h061E, 11);
    chk("par_valid", 32'(rx_valid), 1);
    chk("par_data", 32'(rx_data), 32'h00F);
    chk("par_perr", 32'(rx_perr), 1);
    chk("par_ferr", 32'(rx_ferr), 0);
    rx_ack();

    // 8N1 0x3C with stop bit low, line then held low
    parity_mode = 2'b00;
    rx_send(16'h0078, 10);
    chk("fe_valid", 32'(rx_valid), 1);
    chk("fe_data", 32'(rx_data), 32'h03C);
    chk("fe_ferr", 32'(rx_ferr), 1);
    chk("fe_perr", 32'(rx_perr), 0);
    rx_ack();
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("fe_no_rearm_low", 32'(rx_valid), 0);
    rx_drv = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    rx_send(16'h02B4, 10);
    chk("fe_rearm_valid", 32'(rx_valid), 1);
    chk("fe_rearm_data", 32'(rx_data), 32'h05A);
    chk("fe_rearm_ferr", 32'(rx_ferr), 0);
    rx_ack();

    // 20-clk low glitch must be rejected, then a normal frame still works
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_valid", 32'(rx_valid), 0);
    rx_send(16'h0386, 10);
    chk("glitch_after_valid", 32'(rx_valid), 1);
    chk("glitch_after_data", 32'(rx_data), 32'h0C3);
    rx_ack();

    // overrun: two words without acknowledging
    rx_send(16'h0222, 10);
    chk("ovr_first_valid", 32'(rx_valid), 1);
    chk("ovr_first_flag", 32'(rx_ovr), 0);
    rx_send(16'h0244, 10);
    chk("ovr_second_valid", 32'(rx_valid), 1);
    chk("ovr_second_data", 32'(rx_data), 32'h022);
    chk("ovr_flag", 32'(rx_ovr), 1);
    rx_ack();
    chk("ovr_ack_valid", 32'(rx_valid), 0);
    chk("ovr_ack_flag", 32'(rx_ovr), 0);
    chk("ovr_data_hold", 32'(rx_data), 32'h022);

    // reset in the middle of a TX frame
    @(negedge clk);
    tx_data = 9'h000; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_tx_low", 32'(tx_w), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx_w), 1);
    chk("rst_mid_ready", 32'(tx_ready), 1);
    chk("rst_mid_done", 32'(tx_done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("post_rst_tx", 32'(tx_w), 1);
    chk("post_rst_done", 32'(tx_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
